// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants, state type and CTI helper for wb_burst_master
//
// Purpose: Wishbone cycle-type codes, the master FSM state type and the
//          function that picks the CTI for the beat that follows.
// Contents:
//   CTI_CLASSIC / CTI_INCR / CTI_EOB  Wishbone cycle type identifiers
//   wbm_state_t                       IDLE, WRITE, READ
//   cti_next()                        CTI for the beat presented next

package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } wbm_state_t;

  // remaining counts the beats still to complete, including the one being presented.
  // A zero count means the command is over, so the bus goes back to classic.
  function automatic logic [2:0] cti_next(input logic single, input logic [8:0] remaining);
    if (single || remaining == 9'd0) begin
      return CTI_CLASSIC;
    end else if (remaining == 9'd1) begin
      return CTI_EOB;
    end else begin
      return CTI_INCR;
    end
  endfunction

endpackage

// File: rtl/wb_master_watchdog.sv
// rtl/wb_master_watchdog.sv - stalled-strobe watchdog for wb_burst_master
//
// Purpose: counts consecutive cycles with stb high and no ack; flags the
//          cycle that completes TIMEOUT such stalls so the master can abort.
// Ports:
//   clk_i     in   clock
//   rst_i     in   synchronous active-high reset
//   stb_i     in   Wishbone strobe from the master
//   ack_i     in   Wishbone acknowledge from the slave
//   expire_o  out  high during the TIMEOUT-th consecutive stalled cycle

module wb_master_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic stb_i,
  input  logic ack_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          stall;

  assign stall = stb_i & ~ack_i;

  // cnt_q holds the number of stalled cycles already seen, so the current
  // stalled cycle is number cnt_q+1.
  assign expire_o = stall && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!stall || expire_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_burst_master.sv
// rtl/wb_burst_master.sv - command/stream to Wishbone classic and incrementing-burst master
//
// Purpose: accepts a command (direction, start address, length 1..256), then
//          runs one Wishbone cycle: classic for a single beat, incrementing
//          burst (CTI 010, final beat 111) otherwise. Write beats are pulled
//          from the wdata stream, read beats are pushed out on rdata.
// Ports:
//   wb_clk_i, wb_rst_i                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready                command handshake
//   cmd_we, cmd_addr, cmd_len          direction, byte address, beats (0 = 256)
//   wdata_valid/wdata_ready, wdata     write beat stream
//   rdata_valid, rdata, rdata_last     read beat pulses (no backpressure)
//   cmd_done, cmd_err                  completion pulse, timeout abort flag
//   busy                               command in progress
//   wb_cyc_o .. wb_cti_o               registered Wishbone initiator outputs
//   wb_ack_i, wb_dat_i                 Wishbone slave response

module wb_burst_master
  import wb_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 26,
  parameter int TIMEOUT = 1024
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [7:0]      cmd_len,
  input  logic            wdata_valid,
  output logic            wdata_ready,
  input  logic [DW-1:0]   wdata,
  output logic            rdata_valid,
  output logic [DW-1:0]   rdata,
  output logic            rdata_last,
  output logic            cmd_done,
  output logic            cmd_err,
  output logic            busy,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_addr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [2:0]      wb_cti_o,
  input  logic            wb_ack_i,
  input  logic [DW-1:0]   wb_dat_i
);

  localparam int BW = DW / 8;

  wbm_state_t     state_q, state_d;
  logic           cyc_q, cyc_d;
  logic           stb_q, stb_d;
  logic           we_q, we_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  dat_q, dat_d;
  logic [BW-1:0]  sel_q;
  logic [2:0]     cti_q, cti_d;
  logic           single_q, single_d;
  logic [8:0]     len_q, len_d;
  logic [8:0]     rem_q, rem_d;
  logic [8:0]     loaded_q, loaded_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           rdata_valid_q, rdata_valid_d;
  logic           rdata_last_q, rdata_last_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic           beat;
  logic           wd_expire;
  logic [8:0]     cmd_len9;
  logic [8:0]     rem_dec;

  wb_master_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .stb_i    (stb_q),
    .ack_i    (wb_ack_i),
    .expire_o (wd_expire)
  );

  // ack only counts while a strobe is out.
  assign beat     = stb_q & wb_ack_i;
  assign cmd_len9 = {cmd_len == 8'd0, cmd_len};
  assign rem_dec  = rem_q - 9'd1;

  // Holding off for the cmd_done cycle keeps a new command from overlapping
  // the completion pulse of the previous one.
  assign cmd_ready   = (state_q == IDLE) && !done_q;
  // A new write beat may be loaded when the bus slot is free or being freed
  // this cycle, and only up to the command length.
  assign wdata_ready = (state_q == WRITE) && (!stb_q || wb_ack_i) && (loaded_q < len_q);

  always_comb begin
    state_d       = state_q;
    cyc_d         = cyc_q;
    stb_d         = stb_q;
    we_d          = we_q;
    addr_d        = addr_q;
    dat_d         = dat_q;
    cti_d         = cti_q;
    single_d      = single_q;
    len_d         = len_q;
    rem_d         = rem_q;
    loaded_d      = loaded_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    rdata_last_d  = 1'b0;
    done_d        = 1'b0;
    err_d         = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          we_d     = cmd_we;
          addr_d   = cmd_addr;
          len_d    = cmd_len9;
          rem_d    = cmd_len9;
          loaded_d = 9'd0;
          single_d = (cmd_len9 == 9'd1);
          cyc_d    = 1'b1;
          // Reads strobe at once; writes wait for their first data beat.
          stb_d    = !cmd_we;
          cti_d    = cti_next(cmd_len9 == 9'd1, cmd_len9);
          state_d  = cmd_we ? WRITE : READ;
        end
      end

      WRITE, READ: begin
        if (wd_expire) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          cti_d   = CTI_CLASSIC;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          if (beat) begin
            addr_d = addr_q + AW'(BW);
            rem_d  = rem_dec;
            cti_d  = cti_next(single_q, rem_dec);
            if (state_q == READ) begin
              rdata_d       = wb_dat_i;
              rdata_valid_d = 1'b1;
              rdata_last_d  = (rem_q == 9'd1);
            end
            if (rem_q == 9'd1) begin
              cyc_d   = 1'b0;
              stb_d   = 1'b0;
              cti_d   = CTI_CLASSIC;
              done_d  = 1'b1;
              state_d = IDLE;
            end else if (state_q == WRITE) begin
              // Wait state unless a fresh beat is loaded below.
              stb_d = 1'b0;
            end
          end
          if (wdata_valid && wdata_ready) begin
            dat_d    = wdata;
            stb_d    = 1'b1;
            loaded_d = loaded_q + 9'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q       <= IDLE;
      cyc_q         <= 1'b0;
      stb_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      dat_q         <= '0;
      sel_q         <= '0;
      cti_q         <= CTI_CLASSIC;
      single_q      <= 1'b0;
      len_q         <= 9'd0;
      rem_q         <= 9'd0;
      loaded_q      <= 9'd0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      rdata_last_q  <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      stb_q         <= stb_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      dat_q         <= dat_d;
      sel_q         <= {BW{stb_d}};
      cti_q         <= cti_d;
      single_q      <= single_d;
      len_q         <= len_d;
      rem_q         <= rem_d;
      loaded_q      <= loaded_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      rdata_last_q  <= rdata_last_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = stb_q;
  assign wb_we_o     = we_q;
  assign wb_addr_o   = addr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;
  assign wb_cti_o    = cti_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign rdata_last  = rdata_last_q;
  assign cmd_done    = done_q;
  assign cmd_err     = err_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// tb/tb_wb_burst_master.sv - scoreboard bench for wb_burst_master
module tb_wb_burst_master;

  localparam int DW = 32;
  localparam int AW = 26;
  localparam int BW = DW / 8;
  localparam int TO = 16;

  typedef struct {
    logic [AW-1:0] addr;
    logic [2:0]    cti;
    logic          we;
    logic [DW-1:0] dat;
    logic [BW-1:0] sel;
    int            cyc;
  } beat_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } rd_t;

  logic          clk = 1'b0;
  logic          wb_rst_i = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0]    cmd_len = 8'd0;
  logic          wdata_valid = 1'b0;
  logic          wdata_ready;
  logic [DW-1:0] wdata = '0;
  logic          rdata_valid;
  logic [DW-1:0] rdata;
  logic          rdata_last;
  logic          cmd_done;
  logic          cmd_err;
  logic          busy;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_addr_o;
  logic [DW-1:0] wb_dat_o;
  logic [BW-1:0] wb_sel_o;
  logic [2:0]    wb_cti_o;
  logic          wb_ack_i = 1'b0;
  logic [DW-1:0] wb_dat_i = '0;

  always #5 clk = ~clk;

  wb_burst_master #(.DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last),
    .cmd_done(cmd_done), .cmd_err(cmd_err), .busy(busy),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
  );

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int done_cnt = 0;
  int done_cycle = 0;
  logic done_err = 1'b0;
  logic done_cyc = 1'b0;
  logic done_busy = 1'b0;
  int wait_cycles = 0;
  int stb_cycles = 0;
  int ack_delay = 0;
  logic ack_never = 1'b0;
  int stall = 0;
  logic abort = 1'b0;

  beat_t exp_beats[$];
  beat_t obs_beats[$];
  rd_t   exp_rd[$];
  rd_t   obs_rd[$];
  logic [DW-1:0] wvals[$];

  function automatic logic [DW-1:0] rd_pat(input logic [AW-1:0] a);
    return {6'h2A, a};
  endfunction

  // Expected beats and read data for a command, built from the bus rules.
  function automatic void push_expect(input logic we, input logic [AW-1:0] start, input int len);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      rd_t   r;
      b.addr = start + AW'(i * BW);
      b.cti  = (len == 1) ? 3'b000 : ((i == len - 1) ? 3'b111 : 3'b010);
      b.we   = we;
      b.dat  = we ? wvals[i] : '0;
      b.sel  = '1;
      b.cyc  = 0;
      exp_beats.push_back(b);
      if (!we) begin
        r.data = rd_pat(b.addr);
        r.last = (i == len - 1);
        exp_rd.push_back(r);
      end
    end
  endfunction

  function automatic void clear_sb();
    exp_beats.delete();
    obs_beats.delete();
    exp_rd.delete();
    obs_rd.delete();
  endfunction

  always @(posedge clk) cycle++;

  // Slave model: responds just after each edge with a configurable ack delay.
  always @(posedge clk) begin
    #1;
    if (wb_rst_i || !wb_stb_o || ack_never) begin
      wb_ack_i = 1'b0;
      stall = 0;
    end else if (stall >= ack_delay) begin
      wb_ack_i = 1'b1;
      wb_dat_i = rd_pat(wb_addr_o);
      stall = 0;
    end else begin
      wb_ack_i = 1'b0;
      stall++;
    end
  end

  always @(negedge clk) begin
    if (wb_stb_o && wb_ack_i) begin
      beat_t b;
      b.addr = wb_addr_o; b.cti = wb_cti_o; b.we = wb_we_o;
      b.dat = wb_dat_o; b.sel = wb_sel_o; b.cyc = cycle;
      obs_beats.push_back(b);
    end
    if (rdata_valid) begin
      rd_t r;
      r.data = rdata; r.last = rdata_last;
      obs_rd.push_back(r);
    end
    if (cmd_done) begin
      done_cnt++;
      done_cycle = cycle;
      done_err = cmd_err;
      done_cyc = wb_cyc_o;
      done_busy = busy;
    end
    if (wb_cyc_o && !wb_stb_o) wait_cycles++;
    if (wb_stb_o) stb_cycles++;
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [7:0] len);
    int n;
    n = 0;
    step();
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = len;
    while (!cmd_ready && n < 200) begin step(); n++; end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL cmd_accept: cmd_ready=%b, required 1 within 200 cycles", cmd_ready);
    end
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic drive_wdata(input int gap_after, input int gap_len);
    int i;
    i = 0;
    while (wvals.size() > i && !abort) begin
      int n;
      n = 0;
      step();
      if (i == gap_after) begin
        wdata_valid = 1'b0;
        repeat (gap_len) step();
      end
      wdata = wvals[i];
      wdata_valid = 1'b1;
      while (!wdata_ready && !abort && n < 200) begin step(); n++; end
      if (n >= 200) begin
        checks++; errors++;
        $display("FAIL wdata_accept: beat %0d not taken within 200 cycles", i);
        abort = 1'b1;
      end
      i++;
    end
    step();
    wdata_valid = 1'b0;
  endtask

  task automatic wait_done(input int start, input int budget, output bit ok);
    int n;
    n = 0;
    while (done_cnt == start && n < budget) begin step(); n++; end
    ok = (done_cnt != start);
  endtask

  task automatic test_reset();
    logic [13:0] z;
    wb_rst_i = 1'b1;
    repeat (3) step();
    z = {wb_cyc_o, wb_stb_o, wb_we_o, |wb_addr_o, |wb_dat_o, |wb_sel_o, |wb_cti_o,
         rdata_valid, |rdata, rdata_last, cmd_done, cmd_err, busy, wdata_ready};
    checks++;
    if (z !== 14'd0) begin errors++; $display("FAIL reset_outputs: got %b, required 0", z); end
    wb_rst_i = 1'b0;
    step();
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_idle_ready: got %b, required 1", cmd_ready); end
  endtask

  task automatic test_single_write();
    int start;
    bit ok;
    clear_sb();
    ack_delay = 1;
    wvals = '{32'hDEAD_BEEF};
    push_expect(1'b1, 26'h000100, 1);
    start = done_cnt;
    fork
      issue(1'b1, 26'h000100, 8'd1);
      drive_wdata(-1, 0);
    join
    wait_done(start, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_write_done: no cmd_done, required one"); end
    checks++;
    if (obs_beats.size() != 1) begin errors++; $display("FAIL single_write_beats: got %0d, required 1", obs_beats.size()); end
    for (int i = 0; i < exp_beats.size() && i < obs_beats.size(); i++) begin
      checks++;
      if (obs_beats[i].addr !== exp_beats[i].addr || obs_beats[i].cti !== exp_beats[i].cti ||
          obs_beats[i].we !== 1'b1 || obs_beats[i].sel !== exp_beats[i].sel || obs_beats[i].dat !== exp_beats[i].dat) begin
        errors++;
        $display("FAIL single_write_beat: addr=%h cti=%b sel=%b dat=%h, required addr=%h cti=%b sel=%b dat=%h",
                 obs_beats[i].addr, obs_beats[i].cti, obs_beats[i].sel, obs_beats[i].dat,
                 exp_beats[i].addr, exp_beats[i].cti, exp_beats[i].sel, exp_beats[i].dat);
      end
    end
    if (obs_beats.size() > 0) begin
      checks++;
      if (done_cycle != obs_beats[0].cyc + 1) begin
        errors++; $display("FAIL single_write_done_timing: done at %0d, required %0d", done_cycle, obs_beats[0].cyc + 1);
      end
    end
    checks++;
    if (done_err !== 1'b0) begin errors++; $display("FAIL single_write_err: got %b, required 0", done_err); end
  endtask

  task automatic test_burst_write_gap();
    int start;
    bit ok;
    clear_sb();
    ack_delay = 0;
    wvals = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    push_expect(1'b1, 26'h0000F0, 4);
    start = done_cnt;
    wait_cycles = 0;
    fork
      issue(1'b1, 26'h0000F0, 8'd4);
      drive_wdata(2, 3);
    join
    wait_done(start, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL burst_write_done: no cmd_done, required one"); end
    checks++;
    if (obs_beats.size() != 4) begin errors++; $display("FAIL burst_write_beats: got %0d, required 4", obs_beats.size()); end
    for (int i = 0; i < exp_beats.size() && i < obs_beats.size(); i++) begin
      checks++;
      if (obs_beats[i].addr !== exp_beats[i].addr || obs_beats[i].cti !== exp_beats[i].cti ||
          obs_beats[i].we !== 1'b1 || obs_beats[i].sel !== exp_beats[i].sel || obs_beats[i].dat !== exp_beats[i].dat) begin
        errors++;
        $display("FAIL burst_write_beat%0d: addr=%h cti=%b dat=%h, required addr=%h cti=%b dat=%h", i,
                 obs_beats[i].addr, obs_beats[i].cti, obs_beats[i].dat,
                 exp_beats[i].addr, exp_beats[i].cti, exp_beats[i].dat);
      end
    end
    // one load cycle before the first beat plus the three-cycle data gap
    checks++;
    if (wait_cycles != 4) begin errors++; $display("FAIL burst_write_wait_states: got %0d, required 4", wait_cycles); end
    checks++;
    if (done_err !== 1'b0) begin errors++; $display("FAIL burst_write_err: got %b, required 0", done_err); end
  endtask

  task automatic test_burst_read();
    int start;
    bit ok;
    clear_sb();
    ack_delay = 0;
    push_expect(1'b0, 26'h001000, 8);
    start = done_cnt;
    issue(1'b0, 26'h001000, 8'd8);
    wait_done(start, 100, ok);
    step();
    checks++;
    if (!ok) begin errors++; $display("FAIL burst_read_done: no cmd_done, required one"); end
    checks++;
    if (obs_beats.size() != 8) begin errors++; $display("FAIL burst_read_beats: got %0d, required 8", obs_beats.size()); end
    for (int i = 0; i < exp_beats.size() && i < obs_beats.size(); i++) begin
      checks++;
      if (obs_beats[i].addr !== exp_beats[i].addr || obs_beats[i].cti !== exp_beats[i].cti ||
          obs_beats[i].we !== 1'b0 || obs_beats[i].sel !== exp_beats[i].sel) begin
        errors++;
        $display("FAIL burst_read_beat%0d: addr=%h cti=%b, required addr=%h cti=%b", i,
                 obs_beats[i].addr, obs_beats[i].cti, exp_beats[i].addr, exp_beats[i].cti);
      end
    end
    checks++;
    if (obs_rd.size() != 8) begin errors++; $display("FAIL burst_read_pulses: got %0d, required 8", obs_rd.size()); end
    while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
      rd_t e, o;
      e = exp_rd.pop_front();
      o = obs_rd.pop_front();
      checks++;
      if (o.data !== e.data || o.last !== e.last) begin
        errors++; $display("FAIL burst_read_data: got %h/%b, required %h/%b", o.data, o.last, e.data, e.last);
      end
    end
    checks++;
    if (done_cyc !== 1'b0) begin errors++; $display("FAIL burst_read_cyc_drop: cyc=%b at done, required 0", done_cyc); end
    if (obs_beats.size() > 0) begin
      checks++;
      if (done_cycle != obs_beats[obs_beats.size()-1].cyc + 1) begin
        errors++; $display("FAIL burst_read_done_timing: done at %0d, required %0d", done_cycle, obs_beats[obs_beats.size()-1].cyc + 1);
      end
    end
  endtask

  task automatic test_timeout();
    int start;
    bit ok;
    clear_sb();
    ack_never = 1'b1;
    start = done_cnt;
    stb_cycles = 0;
    issue(1'b0, 26'h002000, 8'd2);
    wait_done(start, 200, ok);
    step();
    checks++;
    if (!ok) begin errors++; $display("FAIL timeout_done: no cmd_done, required one"); end
    checks++;
    if (done_err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b, required 1", done_err); end
    checks++;
    if (stb_cycles != TO) begin errors++; $display("FAIL timeout_stall_len: got %0d, required %0d", stb_cycles, TO); end
    checks++;
    if (done_busy !== 1'b0 || done_cyc !== 1'b0) begin
      errors++; $display("FAIL timeout_idle: busy=%b cyc=%b, required 0 0", done_busy, done_cyc);
    end
    checks++;
    if (obs_rd.size() != 0) begin errors++; $display("FAIL timeout_rdata: got %0d pulses, required 0", obs_rd.size()); end
    ack_never = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    int start;
    bit ok;
    logic [13:0] z;
    clear_sb();
    ack_delay = 0;
    abort = 1'b0;
    wvals = '{32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hA7, 32'hA8};
    start = done_cnt;
    fork
      issue(1'b1, 26'h003000, 8'd8);
      drive_wdata(-1, 0);
      begin
        int n;
        n = 0;
        while (obs_beats.size() < 3 && n < 200) begin step(); n++; end
        checks++;
        if (n >= 200) begin errors++; $display("FAIL reset_mid_reach_beat3: got %0d beats, required 3", obs_beats.size()); end
        wb_rst_i = 1'b1;
        abort = 1'b1;
        step();
        z = {wb_cyc_o, wb_stb_o, wb_we_o, |wb_addr_o, |wb_dat_o, |wb_sel_o, |wb_cti_o,
             rdata_valid, |rdata, rdata_last, cmd_done, cmd_err, busy, wdata_ready};
        checks++;
        if (z !== 14'd0) begin errors++; $display("FAIL reset_mid_outputs: got %b, required 0", z); end
        wb_rst_i = 1'b0;
      end
    join
    abort = 1'b0;
    repeat (5) step();
    checks++;
    if (done_cnt != start) begin errors++; $display("FAIL reset_mid_no_done: got %0d pulses, required 0", done_cnt - start); end
    clear_sb();
    push_expect(1'b0, 26'h000040, 1);
    start = done_cnt;
    issue(1'b0, 26'h000040, 8'd1);
    wait_done(start, 100, ok);
    step();
    checks++;
    if (!ok || done_err !== 1'b0) begin errors++; $display("FAIL reset_follow_done: done=%b err=%b, required 1 0", ok, done_err); end
    checks++;
    if (obs_beats.size() != 1 || obs_beats[0].cti !== 3'b000 || obs_beats[0].addr !== 26'h000040) begin
      errors++; $display("FAIL reset_follow_beat: %0d beats, required one classic beat at 040", obs_beats.size());
    end
    checks++;
    if (obs_rd.size() != 1 || obs_rd[0].data !== exp_rd[0].data || obs_rd[0].last !== 1'b1) begin
      errors++; $display("FAIL reset_follow_rdata: %0d pulses, required 1 with data %h last 1", obs_rd.size(), exp_rd[0].data);
    end
  endtask

  task automatic test_wrap_256();
    int start;
    bit ok;
    int bad;
    logic [AW-1:0] base;
    clear_sb();
    ack_delay = 0;
    base = AW'((1 << AW) - 16);
    push_expect(1'b0, base, 256);
    start = done_cnt;
    issue(1'b0, base, 8'd0);
    wait_done(start, 1000, ok);
    step();
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_done: no cmd_done, required one"); end
    checks++;
    if (obs_beats.size() != 256) begin errors++; $display("FAIL wrap_beats: got %0d, required 256", obs_beats.size()); end
    if (obs_beats.size() > 4) begin
      checks++;
      if (obs_beats[4].addr !== '0) begin errors++; $display("FAIL wrap_addr_beat4: got %h, required 0", obs_beats[4].addr); end
    end
    bad = 0;
    for (int i = 0; i < exp_beats.size() && i < obs_beats.size(); i++) begin
      checks++;
      if (obs_beats[i].addr !== exp_beats[i].addr || obs_beats[i].cti !== exp_beats[i].cti) begin
        errors++;
        if (bad < 4) $display("FAIL wrap_beat%0d: addr=%h cti=%b, required addr=%h cti=%b", i,
                              obs_beats[i].addr, obs_beats[i].cti, exp_beats[i].addr, exp_beats[i].cti);
        bad++;
      end
    end
    checks++;
    if (obs_rd.size() != 256) begin errors++; $display("FAIL wrap_pulses: got %0d, required 256", obs_rd.size()); end
    while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
      rd_t e, o;
      e = exp_rd.pop_front();
      o = obs_rd.pop_front();
      checks++;
      if (o.data !== e.data || o.last !== e.last) begin
        errors++;
        if (bad < 8) $display("FAIL wrap_rdata: got %h/%b, required %h/%b", o.data, o.last, e.data, e.last);
        bad++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "global timeout");
  end

  initial begin
    test_reset();
    test_single_write();
    test_burst_write_gap();
    test_burst_read();
    test_timeout();
    test_reset_mid_write();
    test_wrap_256();
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
